// File: rtl/peak_meter_pkg.sv
// Shared helpers for the peak_meter slice: widths, window length and sample magnitude.
// PEAK_ABS_EN selects signed two's-complement input with saturating |din|.
package peak_meter_pkg;

   localparam int MAG_W        = 32;
   localparam int WIN_LOG2_DEF = 9;
   localparam int WIN_LAST     = 2**WIN_LOG2_DEF - 1;

   function automatic int ch_width(input int channels);
      int w;
      if (channels > 1) begin
         w = $clog2(channels);
      end else begin
         w = 1;
      end
      return w;
   endfunction

   function automatic int win_last(input int win_log2);
      return (2**win_log2) - 1;
   endfunction

   // Operates on a zero-extended sample of width w (w < MAG_W).
   function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] x, input int w);
      logic [MAG_W-1:0] mask;
      logic [MAG_W-1:0] v;
      logic [MAG_W-1:0] res;
`ifdef PEAK_ABS_EN
      logic [MAG_W-1:0] neg;
      logic [MAG_W-1:0] pos_max;
`endif
      mask = (32'd1 << w) - 32'd1;
      v    = x & mask;
`ifdef PEAK_ABS_EN
      pos_max = (32'd1 << (w - 1)) - 32'd1;
      if (v[w-1]) begin
         neg = (~v + 32'd1) & mask;
         // The most-negative code has no positive twin; clamp it.
         if (neg > pos_max) begin
            res = pos_max;
         end else begin
            res = neg;
         end
      end else begin
         res = v;
      end
`else
      res = v;
`endif
      return res;
   endfunction

endpackage

// File: rtl/peak_meter_if.sv
// Sample stream in / published peaks out for peak_meter.
interface peak_meter_if
   import peak_meter_pkg::*;
#(
   parameter int BUS_WIDTH = 12,
   parameter int CHANNELS  = 2
);
   localparam int CH_W = ch_width(CHANNELS);

   logic                          clr;
   logic                          din_valid;
   logic [CH_W-1:0]               din_ch;
   logic [BUS_WIDTH-1:0]          din;
   logic [CHANNELS*BUS_WIDTH-1:0] peak_out;
   logic                          peak_valid;

   modport master (
      output clr, din_valid, din_ch, din,
      input  peak_out, peak_valid
   );

   modport slave (
      input  clr, din_valid, din_ch, din,
      output peak_out, peak_valid
   );

endinterface

// File: rtl/peak_meter_channel.sv
// One channel's running maximum with a fresh flag that makes the next sample overwrite it.
module peak_channel
   import peak_meter_pkg::*;
#(
   parameter int BUS_WIDTH = 12
)(
   input  logic                 dclk,
   input  logic                 rst,
   input  logic                 accept_i,
   input  logic                 first_i,
   input  logic [BUS_WIDTH-1:0] m_i,
   output logic [BUS_WIDTH-1:0] max_next_o
);

   logic [BUS_WIDTH-1:0] max_q;
   logic [BUS_WIDTH-1:0] max_d;
   logic                 fresh_q;
   logic                 fresh_d;

   always_comb begin
      max_d   = max_q;
      fresh_d = fresh_q;
      if (accept_i) begin
         if (fresh_q || (m_i > max_q)) begin
            max_d = m_i;
         end else begin
            max_d = max_q;
         end
         fresh_d = 1'b0;
      end else begin
         max_d = max_q;
      end
      // A window restart re-arms the flag even when this channel also sampled.
      if (first_i) begin
         fresh_d = 1'b1;
      end else begin
         fresh_d = fresh_d;
      end
   end

   assign max_next_o = max_d;

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         max_q   <= {BUS_WIDTH{1'b0}};
         fresh_q <= 1'b1;
      end else begin
         max_q   <= max_d;
         fresh_q <= fresh_d;
      end
   end

endmodule

// File: rtl/peak_meter.sv
// Multi-channel windowed peak detector: frame counting, window close/clr decode, peak register.
// Build option PEAK_ABS_EN: treat din as signed and track |din|.
module peak_meter
   import peak_meter_pkg::*;
#(
   parameter int BUS_WIDTH = 12,
   parameter int CHANNELS  = 2,
   parameter int WIN_LOG2  = WIN_LOG2_DEF
)(
   input  logic         dclk,
   input  logic         rst,
   peak_meter_if.slave  bus
);

   localparam int                  CH_W       = ch_width(CHANNELS);
   localparam logic [CH_W:0]       CH_LIMIT   = CHANNELS[CH_W:0];
   localparam logic [CH_W-1:0]     LAST_CH    = CH_W'(CHANNELS - 1);
   localparam logic [WIN_LOG2-1:0] LAST_FRAME = WIN_LOG2'(win_last(WIN_LOG2));

   logic                          accept_s;
   logic                          frame_end_s;
   logic                          close_s;
   logic                          first_s;
   logic [WIN_LOG2-1:0]           cnt_q;
   logic [WIN_LOG2-1:0]           cnt_d;
   logic [CHANNELS*BUS_WIDTH-1:0] max_next_s;
   logic [CHANNELS*BUS_WIDTH-1:0] peak_q;
   logic [CHANNELS*BUS_WIDTH-1:0] peak_d;
   logic                          peak_valid_q;
   logic                          peak_valid_d;
   logic [MAG_W-1:0]              mag_full_s;
   logic [BUS_WIDTH-1:0]          m_s;
   logic                          unused_mag_hi_s;

   assign mag_full_s      = magnitude({{(MAG_W-BUS_WIDTH){1'b0}}, bus.din}, BUS_WIDTH);
   assign m_s             = mag_full_s[BUS_WIDTH-1:0];
   assign unused_mag_hi_s = ^mag_full_s[MAG_W-1:BUS_WIDTH];

   // clr discards the same-cycle sample, so it also suppresses frame end and close.
   always_comb begin
      accept_s    = 1'b0;
      frame_end_s = 1'b0;
      close_s     = 1'b0;
      if (bus.din_valid && ({1'b0, bus.din_ch} < CH_LIMIT) && !bus.clr) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (accept_s && (bus.din_ch == LAST_CH)) begin
         frame_end_s = 1'b1;
      end else begin
         frame_end_s = 1'b0;
      end
      if (frame_end_s && (cnt_q == LAST_FRAME)) begin
         close_s = 1'b1;
      end else begin
         close_s = 1'b0;
      end
   end

   assign first_s = close_s | bus.clr;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic sel_s;
      assign sel_s = accept_s && (bus.din_ch == CH_W'(g));
      peak_channel #(
         .BUS_WIDTH (BUS_WIDTH)
      ) u_ch (
         .dclk       (dclk),
         .rst        (rst),
         .accept_i   (sel_s),
         .first_i    (first_s),
         .m_i        (m_s),
         .max_next_o (max_next_s[g*BUS_WIDTH +: BUS_WIDTH])
      );
   end

   always_comb begin
      cnt_d        = cnt_q;
      peak_d       = peak_q;
      peak_valid_d = 1'b0;
      if (bus.clr) begin
         cnt_d = {WIN_LOG2{1'b0}};
      end else if (frame_end_s) begin
         cnt_d = cnt_q + WIN_LOG2'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
      // Publish max_next so the closing sample is already merged.
      if (close_s) begin
         peak_d       = max_next_s;
         peak_valid_d = 1'b1;
      end else begin
         peak_d       = peak_q;
         peak_valid_d = 1'b0;
      end
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         cnt_q        <= {WIN_LOG2{1'b0}};
         peak_q       <= {(CHANNELS*BUS_WIDTH){1'b0}};
         peak_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         peak_q       <= peak_d;
         peak_valid_q <= peak_valid_d;
      end
   end

   assign bus.peak_out   = peak_q;
   assign bus.peak_valid = peak_valid_q;

endmodule
